// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nn_pkg
// Description : Shared constants and state type for the classifier back end.
// Revision    : 1.0 - initial release
// ============================================================================
package nn_pkg;

    localparam int NUM_ROWS  = 10;
    localparam int ROW_SEL_W = 4;
    localparam int RESULT_W  = 32;

    localparam logic [ROW_SEL_W-1:0] NO_DIGIT = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } argmax_state_t;

endpackage
`default_nettype wire

// File: rtl/argmax_tracker.sv
`default_nettype none
// ============================================================================
// Module      : argmax_tracker
// Description : Running signed maximum with index; ties keep the earlier index.
// Revision    : 1.0 - initial release
// ============================================================================
module argmax_tracker
    import nn_pkg::*;
#(
    parameter int IDX_W = ROW_SEL_W,
    parameter int VAL_W = RESULT_W
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    i_clear,
    input  logic                    i_update,
    input  logic [IDX_W-1:0]        i_idx,
    input  logic signed [VAL_W-1:0] i_value,
    output logic [IDX_W-1:0]        o_best_idx,
    output logic signed [VAL_W-1:0] o_best_val,
    output logic                    o_has_best
);

    logic                    r_has_best;
    logic [IDX_W-1:0]        r_best_idx;
    logic signed [VAL_W-1:0] r_best_val;
    logic                    w_take;

    // Strict greater-than: an equal later score never displaces the earlier row
    assign w_take = i_update && (!r_has_best || (i_value > r_best_val));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_has_best <= 1'b0;
            r_best_idx <= '0;
            r_best_val <= '0;
        end else if (i_clear) begin
            r_has_best <= 1'b0;
            r_best_idx <= '0;
            r_best_val <= '0;
        end else if (w_take) begin
            r_has_best <= 1'b1;
            r_best_idx <= i_idx;
            r_best_val <= i_value;
        end
    end

    assign o_best_idx = r_best_idx;
    assign o_best_val = r_best_val;
    assign o_has_best = r_has_best;

endmodule
`default_nettype wire

// File: rtl/argmax_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : argmax_sequencer
// Description : Sequences multiplier rows, stores scores, reports argmax digit.
// Revision    : 1.0 - initial release
// ============================================================================
module argmax_sequencer #(
    parameter int NUM_ROWS = nn_pkg::NUM_ROWS,
    parameter int RESULT_W = nn_pkg::RESULT_W
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          start,
    output logic                          begin_mult,
    output logic [nn_pkg::ROW_SEL_W-1:0]  row_select,
    input  logic                          done_row,
    input  logic                          w_result_ena,
    input  logic [RESULT_W-1:0]           row_result,
    input  logic                          overflow,
    input  logic [nn_pkg::ROW_SEL_W-1:0]  score_sel,
    output logic [RESULT_W-1:0]           score_out,
    output logic                          busy,
    output logic [nn_pkg::ROW_SEL_W-1:0]  digit,
    output logic                          digit_valid,
    output logic [RESULT_W-1:0]           max_value,
    output logic [NUM_ROWS-1:0]           ovf_mask
);
    import nn_pkg::*;

    localparam logic [ROW_SEL_W-1:0] c_LAST_ROW = ROW_SEL_W'(NUM_ROWS - 1);

    argmax_state_t               r_state;
    argmax_state_t               w_state_next;
    logic [ROW_SEL_W-1:0]        r_row_select;
    logic [NUM_ROWS-1:0]         r_ovf_mask;
    logic [RESULT_W-1:0]         r_scores [NUM_ROWS];
    logic [RESULT_W-1:0]         r_score_out;
    logic [RESULT_W-1:0]         r_max_value;
    logic [ROW_SEL_W-1:0]        r_digit;
    logic                        w_clear;
    logic                        w_row_done;
    logic                        w_row_valid;
    logic [ROW_SEL_W-1:0]        w_best_idx;
    logic signed [RESULT_W-1:0]  w_best_val;
    logic                        w_has_best;
    logic [ROW_SEL_W-1:0]        w_final_digit;
    logic [RESULT_W-1:0]         w_final_max;

    assign w_clear     = (r_state == ST_IDLE) && start;
    assign w_row_done  = (r_state == ST_WAIT) && done_row;
    assign w_row_valid = w_result_ena && !overflow;

    always_comb begin
        w_state_next = r_state;
        begin_mult   = 1'b0;
        busy         = 1'b1;
        digit_valid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) w_state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                begin_mult   = 1'b1;
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (done_row)
                    w_state_next = (r_row_select == c_LAST_ROW) ? ST_DONE : ST_ISSUE;
            end
            ST_DONE: begin
                digit_valid  = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state      <= ST_IDLE;
            r_row_select <= '0;
            r_ovf_mask   <= '0;
            r_digit      <= NO_DIGIT;
            r_max_value  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_clear) begin
                r_row_select <= '0;
                r_ovf_mask   <= '0;
            end else if (w_row_done) begin
                if (!w_row_valid) r_ovf_mask[r_row_select] <= 1'b1;
                if (r_row_select != c_LAST_ROW) r_row_select <= r_row_select + 1'b1;
            end else if (r_state == ST_DONE) begin
                r_row_select <= '0;
                r_digit      <= w_final_digit;
                r_max_value  <= w_final_max;
            end
        end
    end

    // Invalid rows store zero so readback never exposes an overflowed value
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < NUM_ROWS; i++) r_scores[i] <= '0;
            r_score_out <= '0;
        end else begin
            if (w_row_done) r_scores[r_row_select] <= w_row_valid ? row_result : '0;
            r_score_out <= (int'(score_sel) < NUM_ROWS) ? r_scores[score_sel] : '0;
        end
    end

    argmax_tracker #(
        .IDX_W (ROW_SEL_W),
        .VAL_W (RESULT_W)
    ) u_tracker (
        .clk        (clk),
        .n_rst      (n_rst),
        .i_clear    (w_clear),
        .i_update   (w_row_done && w_row_valid),
        .i_idx      (r_row_select),
        .i_value    ($signed(row_result)),
        .o_best_idx (w_best_idx),
        .o_best_val (w_best_val),
        .o_has_best (w_has_best)
    );

    assign w_final_digit = w_has_best ? w_best_idx : NO_DIGIT;
    assign w_final_max   = w_has_best ? w_best_val : '0;

    // Result is visible during the DONE pulse, then held in registers
    assign digit      = (r_state == ST_DONE) ? w_final_digit : r_digit;
    assign max_value  = (r_state == ST_DONE) ? w_final_max   : r_max_value;
    assign row_select = r_row_select;
    assign ovf_mask   = r_ovf_mask;
    assign score_out  = r_score_out;

endmodule
`default_nettype wire

// File: tb/tb_argmax_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_argmax_sequencer
// Description : Directed self-checking bench with a per-run argmax model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_argmax_sequencer;

    localparam int NR = 10;
    localparam int RW = 32;

    logic          tb_clk = 1'b0;
    logic          n_rst;
    logic          start;
    logic          begin_mult;
    logic [3:0]    row_select;
    logic          done_row;
    logic          w_result_ena;
    logic [RW-1:0] row_result;
    logic          overflow;
    logic [3:0]    score_sel;
    logic [RW-1:0] score_out;
    logic          busy;
    logic [3:0]    digit;
    logic          digit_valid;
    logic [RW-1:0] max_value;
    logic [NR-1:0] ovf_mask;

    always #5 tb_clk = ~tb_clk;

    argmax_sequencer #(.NUM_ROWS(NR), .RESULT_W(RW)) dut (
        .clk(tb_clk), .n_rst(n_rst), .start(start), .begin_mult(begin_mult),
        .row_select(row_select), .done_row(done_row), .w_result_ena(w_result_ena),
        .row_result(row_result), .overflow(overflow), .score_sel(score_sel),
        .score_out(score_out), .busy(busy), .digit(digit), .digit_valid(digit_valid),
        .max_value(max_value), .ovf_mask(ovf_mask)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Stimulus table for one image and the model's verdict on it
    int            t_score [NR];
    bit            t_ena   [NR];
    bit            t_ovf   [NR];
    logic [3:0]    run_digit;
    logic [RW-1:0] run_max;
    logic [NR-1:0] run_mask;
    logic [RW-1:0] run_scores [NR];

    logic [3:0]    held_digit = 4'hF;
    logic [RW-1:0] held_max   = '0;
    logic [NR-1:0] held_mask  = '0;
    int            issue_cnt  = 0;
    int            dv_cnt     = 0;
    bit            run_active = 1'b0;
    bit            prev_bm    = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_run();
        int best_i = -1;
        int best_v = 0;
        run_mask = '0;
        for (int r = 0; r < NR; r++) begin
            if (t_ena[r] && !t_ovf[r]) begin
                run_scores[r] = t_score[r];
                if (best_i < 0 || t_score[r] > best_v) begin
                    best_i = r;
                    best_v = t_score[r];
                end
            end else begin
                run_scores[r] = '0;
                run_mask[r]   = 1'b1;
            end
        end
        run_digit = (best_i < 0) ? 4'hF : 4'(best_i);
        run_max   = (best_i < 0) ? '0 : RW'(best_v);
    endfunction

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(posedge tb_clk);
            #1;
            if (!n_rst) begin
                held_digit = 4'hF;
                held_max   = '0;
                held_mask  = '0;
                prev_bm    = 1'b0;
            end else begin
                if (begin_mult) begin
                    check("bm_in_run", 64'(run_active), 64'd1);
                    check("bm_row_sel", 64'(row_select), 64'(issue_cnt));
                    check("bm_single_cycle", 64'(prev_bm), 64'd0);
                    issue_cnt++;
                end
                prev_bm = begin_mult;
                if (digit_valid) begin
                    check("dv_in_run", 64'(run_active), 64'd1);
                    check("dv_row_count", 64'(issue_cnt), 64'(NR));
                    check("dv_digit", 64'(digit), 64'(run_digit));
                    check("dv_max", 64'(max_value), 64'(run_max));
                    check("dv_mask", 64'(ovf_mask), 64'(run_mask));
                    held_digit = run_digit;
                    held_max   = run_max;
                    held_mask  = run_mask;
                    run_active = 1'b0;
                    dv_cnt++;
                end else begin
                    check("digit_hold", 64'(digit), 64'(held_digit));
                    check("max_hold", 64'(max_value), 64'(held_max));
                    if (!busy) check("mask_idle", 64'(ovf_mask), 64'(held_mask));
                end
            end
        end
    end

    task automatic run_image(input int abort_row, input bit poke_start);
        int n;
        int dv0;
        dv0 = dv_cnt;
        model_run();
        issue_cnt  = 0;
        run_active = 1'b1;
        @(negedge tb_clk); start = 1'b1;
        @(negedge tb_clk); start = 1'b0;
        for (int r = 0; r < NR; r++) begin
            n = 0;
            while (!begin_mult && n < 50) begin
                @(negedge tb_clk);
                n++;
            end
            check("bm_wait", 64'(begin_mult), 64'd1);
            if (!begin_mult) return;
            repeat (1 + (r % 3)) @(negedge tb_clk);
            if (r == abort_row) begin
                n_rst      = 1'b0;
                run_active = 1'b0;
                #1;
                check("abort_busy", 64'(busy), 64'd0);
                check("abort_bm", 64'(begin_mult), 64'd0);
                check("abort_dv", 64'(digit_valid), 64'd0);
                check("abort_digit", 64'(digit), 64'hF);
                check("abort_max", 64'(max_value), 64'd0);
                repeat (2) @(negedge tb_clk);
                n_rst = 1'b1;
                return;
            end
            if (poke_start && r == 3) begin
                start = 1'b1;
                @(negedge tb_clk);
                start = 1'b0;
            end
            done_row     = 1'b1;
            w_result_ena = t_ena[r];
            overflow     = t_ovf[r];
            row_result   = RW'(t_score[r]);
            @(negedge tb_clk);
            done_row     = 1'b0;
            w_result_ena = 1'b0;
            overflow     = 1'b0;
            row_result   = 32'hDEAD_BEEF;
        end
        n = 0;
        while (busy && n < 10) begin
            @(negedge tb_clk);
            n++;
        end
        check("run_end_idle", 64'(busy), 64'd0);
        check("dv_once", 64'(dv_cnt - dv0), 64'd1);
    endtask

    task automatic check_scores();
        logic [RW-1:0] exp;
        for (int s = 0; s < 16; s++) begin
            @(negedge tb_clk);
            score_sel = 4'(s);
            @(posedge tb_clk);
            #1;
            exp = (s < NR) ? run_scores[s] : '0;
            check("score_out", 64'(score_out), 64'(exp));
        end
    endtask

    task automatic read_score(input int sel, input logic [RW-1:0] exp);
        @(negedge tb_clk);
        score_sel = 4'(sel);
        @(posedge tb_clk);
        #1;
        check("score_lit", 64'(score_out), 64'(exp));
    endtask

    task automatic set_all_valid();
        for (int r = 0; r < NR; r++) begin
            t_ena[r] = 1'b1;
            t_ovf[r] = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst = 1'b1; start = 1'b0; done_row = 1'b0; w_result_ena = 1'b0;
        row_result = '0; overflow = 1'b0; score_sel = '0;
        #2 n_rst = 1'b0;
        repeat (3) @(negedge tb_clk);
        n_rst = 1'b1;
        check("rst_digit", 64'(digit), 64'hF);
        check("rst_max", 64'(max_value), 64'd0);
        check("rst_mask", 64'(ovf_mask), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_bm", 64'(begin_mult), 64'd0);
        check("rst_dv", 64'(digit_valid), 64'd0);
        check("rst_row_sel", 64'(row_select), 64'd0);
        check("rst_score_out", 64'(score_out), 64'd0);

        // Tie between rows 1 and 3 resolves to row 1
        t_score = '{5, 9, -3, 9, 0, 1, 2, 3, 4, 7};
        set_all_valid();
        run_image(-1, 1'b0);
        check("t1_digit", 64'(digit), 64'd1);
        check("t1_max", 64'(max_value), 64'd9);
        check("t1_mask", 64'(ovf_mask), 64'd0);
        check_scores();

        for (int r = 0; r < NR; r++) t_score[r] = r - 10;
        run_image(-1, 1'b0);
        check("t2_digit", 64'(digit), 64'd9);
        check("t2_max", 64'(max_value), 64'hFFFF_FFFF);
        check_scores();

        t_score = '{10, 20, 50, -5, 1000, 3, 7, -50, 0, 49};
        set_all_valid();
        t_ovf[4] = 1'b1;
        run_image(-1, 1'b0);
        check("t3_digit", 64'(digit), 64'd2);
        check("t3_max", 64'(max_value), 64'd50);
        check("t3_mask", 64'(ovf_mask), 64'h010);
        read_score(4, '0);
        read_score(2, 32'd50);
        check_scores();

        for (int r = 0; r < NR; r++) t_ena[r] = 1'b0;
        run_image(-1, 1'b0);
        check("t4_digit", 64'(digit), 64'hF);
        check("t4_max", 64'(max_value), 64'd0);
        check("t4_mask", 64'(ovf_mask), 64'h3FF);

        // Dropped start mid-run, then a stray done_row while idle
        t_score = '{5, 9, -3, 9, 0, 1, 2, 3, 4, 7};
        set_all_valid();
        run_image(-1, 1'b1);
        check("t5_digit", 64'(digit), 64'd1);
        @(negedge tb_clk); done_row = 1'b1;
        @(negedge tb_clk); done_row = 1'b0;
        repeat (3) @(negedge tb_clk);
        check("t5_idle_busy", 64'(busy), 64'd0);

        run_image(6, 1'b0);
        repeat (2) @(negedge tb_clk);
        check("t6_digit", 64'(digit), 64'hF);
        check("t6_max", 64'(max_value), 64'd0);
        check("t6_mask", 64'(ovf_mask), 64'd0);
        read_score(0, '0);
        t_score = '{10, 20, 50, -5, 1000, 3, 7, -50, 0, 49};
        set_all_valid();
        t_ovf[4] = 1'b1;
        run_image(-1, 1'b0);
        check("t6_rerun_digit", 64'(digit), 64'd2);
        check("t6_rerun_mask", 64'(ovf_mask), 64'h010);

        repeat (3) @(negedge tb_clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/argmax_sequencer.md
# argmax_sequencer

Downstream controller and consumer for `multiplier`. Issues `begin_mult` for output rows 0..NUM_ROWS-1 in turn and captures each signed `row_result` as the row finishes. Tracks the running maximum and reports the winning row index as the classified digit. Also records per-row overflow and holds all row scores for readback.

## Interface
- `NUM_ROWS`, 10: number of output rows (classes) to sequence.
- `RESULT_W`, 32: width of `row_result` / stored scores.
- `clk`  in  1: system clock, rising edge.
- `n_rst`  in  1: asynchronous, active-low reset.
- `start`  in  1: single-cycle request to classify one image; ignored unless IDLE.
- `begin_mult`  out  1: one-cycle pulse to `multiplier`.
- `row_select`  out  4: row currently being computed; stable from the ISSUE cycle until that row's `done_row`.
- `done_row`  in  1: multiplier finished current row.
- `w_result_ena`  in  1: `row_result` is a valid write this cycle.
- `row_result`  in  RESULT_W: signed two's-complement row score.
- `overflow`  in  1: current row result overflowed.
- `score_sel`  in  4: readback index.
- `score_out`  out  RESULT_W: registered stored score of row `score_sel`; 0 if `score_sel` ≥ NUM_ROWS.
- `busy`  out  1: high in every state except IDLE.
- `digit`  out  4: winning row index; 4'hF if no valid row.
- `digit_valid`  out  1: one-cycle pulse when `digit` is updated.
- `max_value`  out  RESULT_W: winning score; 0 if no valid row.
- `ovf_mask`  out  NUM_ROWS: bit r set if row r was invalid in the last run.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - `start`=1 clears `ovf_mask`, the best-valid flag and `row_select`, then goes to ISSUE.
  - `digit` and `max_value` hold their previous-run values.
- ISSUE: `begin_mult`=1 for exactly this cycle; next state is WAIT.
- WAIT: waits for `done_row`=1.
  - Row is valid if `w_result_ena`=1 and `overflow`=0 in that cycle.
  - A valid row is stored into `score[row_select]`.
  - A valid row replaces the best when no best exists or when it is signed-strictly greater than the best. Ties keep the lower index.
  - An invalid row sets `ovf_mask[row_select]` and stores 0.
  - If `row_select` = NUM_ROWS-1, go to DONE; otherwise increment `row_select` and go to ISSUE.
- DONE:
  - `digit` ← best index, or 4'hF if no valid row.
  - `max_value` ← best score, or 0 if no valid row.
  - `digit_valid`=1 for this one cycle; next state is IDLE with `row_select` ← 0.
- Compare is full-width signed; no saturation; scores stored unmodified.
- `start` while busy is dropped, not queued.
- `done_row` outside WAIT is ignored.

## Timing
- Reset (async assert, sync release): state IDLE; all outputs 0 except `digit`=4'hF. Stored scores, best value and `ovf_mask` are cleared.
- Reset mid-run aborts immediately: `begin_mult` falls asynchronously and no `digit_valid` is produced.
- Run start: `start` sampled at edge k; `busy` and `begin_mult` are high after edge k.
- Row advance: `done_row` sampled at edge m (not last row); the next `begin_mult` is high after edge m, with `row_select` already incremented.
- Last row: `done_row` at edge m gives `digit_valid` high after edge m, and IDLE (`busy`=0) after edge m+1.
- Overhead: 2 cycles per run plus 1 cycle per row, on top of multiplier latency.
- `score_out` has 1-cycle read latency. A same-cycle write to the selected row shows the new value one cycle after the write edge.

## Structure
- Shared package `nn_pkg`:
  - `NUM_ROWS`, `ROW_SEL_W`=4, `RESULT_W`.
  - `NO_DIGIT`=4'hF.
  - State enum `argmax_state_t`.
- Sub-module `argmax_tracker`:
  - Inputs: clear, update strobe, index, signed value.
  - Outputs: best index, best value, has_best.
  - Separates the compare logic from the sequencing FSM.

## Test plan
- Scores {5,9,-3,9,0,1,2,3,4,7}, all valid -> `begin_mult` pulses once per row for rows 0..9; `digit`=1, `max_value`=9, `ovf_mask`=0, `digit_valid` for 1 cycle.
- All scores negative {-10..-1} in order -> `digit`=9, `max_value`=-1, confirming signed compare.
- Row 4 = 1000 with `overflow`=1, others ≤ 50 with max at row 2 -> `digit`=2, `ovf_mask`=10'h010, `score` row 4 reads 0.
- Every row has `w_result_ena`=0 -> `digit`=4'hF, `max_value`=0, `ovf_mask`=10'h3FF.
- `start` pulsed during WAIT of row 3, and a `done_row` in IDLE -> no extra rows, exactly 10 `begin_mult` pulses.
- `n_rst` low during WAIT of row 6 -> outputs return to reset values at once, no `digit_valid`; a new `start` then runs rows 0..9 cleanly.
